// File: rtl/regfile_sb_if.sv
// regfile_sb_if: issue, writeback, read and difftest signals of the scoreboarded register file
interface regfile_sb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  logic                 iss_valid_i;
  logic [AW-1:0]        iss_rd_i;
  logic                 iss_ready_o;
  logic                 flush_i;
  logic [NWR-1:0]       we_i;
  logic [NWR*AW-1:0]    waddr_i;
  logic [NWR*XLEN-1:0]  wdata_i;
  logic [NRD*AW-1:0]    raddr_i;
  logic [NRD*XLEN-1:0]  rdata_o;
  logic [NRD-1:0]       rbusy_o;
  logic [NREG*XLEN-1:0] diff_reg_o;
  modport master (
    output iss_valid_i, iss_rd_i, flush_i, we_i, waddr_i, wdata_i, raddr_i,
    input  iss_ready_o, rdata_o, rbusy_o, diff_reg_o
  );
  modport slave (
    input  iss_valid_i, iss_rd_i, flush_i, we_i, waddr_i, wdata_i, raddr_i,
    output iss_ready_o, rdata_o, rbusy_o, diff_reg_o
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass and saturating per-register pending counters
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int NRD  = 2,
  parameter int CW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int DW = $clog2(NWR + 1);
  localparam int SW = (CW > DW ? CW : DW) + 1;
  localparam logic [CW-1:0] CMAX = '1;
  logic [XLEN-1:0] regs  [NREG];
  logic [CW-1:0]   pend  [NREG];
  logic [XLEN-1:0] wval  [NREG];
  logic            wen   [NREG];
  logic [DW-1:0]   dec   [NREG];
  logic            inc   [NREG];
  logic [SW-1:0]   up    [NREG];
  logic [CW-1:0]   pnext [NREG];
  logic            iss_ready;
  // readiness ignores same-cycle writebacks, so an accepted issue can never push pend past CMAX
  assign iss_ready = bus.iss_rd_i == '0 || pend[bus.iss_rd_i] != CMAX;
  assign bus.iss_ready_o = iss_ready;
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wen[r] = 1'b0;
      wval[r] = regs[r];
      dec[r] = '0;
      for (int p = 0; p < NWR; p++)
        if (r != 0 && bus.we_i[p] && bus.waddr_i[p*AW +: AW] == AW'(r)) begin
          wen[r] = 1'b1;
          wval[r] = bus.wdata_i[p*XLEN +: XLEN];
          dec[r] = dec[r] + DW'(1);
        end
      inc[r] = r != 0 && bus.iss_valid_i && iss_ready && bus.iss_rd_i == AW'(r);
      up[r] = SW'(pend[r]) + SW'(inc[r]);
      pnext[r] = (bus.flush_i || up[r] <= SW'(dec[r])) ? '0 : CW'(up[r] - SW'(dec[r]));
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.raddr_i[k*AW +: AW];
    assign bus.rdata_o[k*XLEN +: XLEN] = wval[a];
    assign bus.rbusy_o[k] = SW'(pend[a]) > SW'(dec[a]);
  end
  for (genvar r = 0; r < NREG; r++) begin : g_diff
    assign bus.diff_reg_o[r*XLEN +: XLEN] = regs[r];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wen[r]) regs[r] <= wval[r];
        pend[r] <= pnext[r];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed scoreboard bench for regfile_sb against an array-based model
module tb_regfile_sb;
  localparam int XLEN = 64, NREG = 32, NWR = 2, NRD = 2, CW = 2;
  localparam int AW = $clog2(NREG);
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 ready;
    logic [NREG*XLEN-1:0] diff;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NWR(NWR), .NRD(NRD)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NWR(NWR), .NRD(NRD), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [XLEN-1:0] mreg [NREG];
  int              mpend [NREG];
  exp_t            q [$];
  exp_t            me;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string n, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp_v, $time);
    end
  endtask

  // expected outputs come from the state before this cycle's edge; the model then advances
  task automatic model_step();
    exp_t e;
    int dec [NREG];
    int a, n;
    if (!rst)
      for (int r = 0; r < NREG; r++) begin
        mreg[r] = '0;
        mpend[r] = 0;
      end
    for (int r = 0; r < NREG; r++) dec[r] = 0;
    for (int p = 0; p < NWR; p++)
      if (bus.we_i[p]) dec[int'(bus.waddr_i[p*AW +: AW])]++;
    dec[0] = 0;
    a = int'(bus.iss_rd_i);
    e.ready = (a == 0) || (mpend[a] < CMAX);
    for (int k = 0; k < NRD; k++) begin
      a = int'(bus.raddr_i[k*AW +: AW]);
      e.rdata[k*XLEN +: XLEN] = (a == 0) ? '0 : mreg[a];
      for (int p = 0; p < NWR; p++)
        if (a != 0 && bus.we_i[p] && int'(bus.waddr_i[p*AW +: AW]) == a)
          e.rdata[k*XLEN +: XLEN] = bus.wdata_i[p*XLEN +: XLEN];
      e.rbusy[k] = (a != 0) && (mpend[a] > dec[a]);
    end
    for (int r = 0; r < NREG; r++) e.diff[r*XLEN +: XLEN] = mreg[r];
    q.push_back(e);
    if (rst) begin
      for (int r = 1; r < NREG; r++) begin
        n = mpend[r] + ((bus.iss_valid_i && e.ready && int'(bus.iss_rd_i) == r) ? 1 : 0) - dec[r];
        mpend[r] = bus.flush_i ? 0 : (n < 0 ? 0 : n);
      end
      for (int p = 0; p < NWR; p++)
        if (bus.we_i[p] && bus.waddr_i[p*AW +: AW] != '0)
          mreg[int'(bus.waddr_i[p*AW +: AW])] = bus.wdata_i[p*XLEN +: XLEN];
    end
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] rd, input logic f,
                     input logic [NWR-1:0] w, input logic [NWR*AW-1:0] wa,
                     input logic [NWR*XLEN-1:0] wd, input logic [NRD*AW-1:0] ra, input logic rn);
    @(posedge clk);
    #2;
    bus.iss_valid_i = v;
    bus.iss_rd_i = rd;
    bus.flush_i = f;
    bus.we_i = w;
    bus.waddr_i = wa;
    bus.wdata_i = wd;
    bus.raddr_i = ra;
    rst = rn;
    model_step();
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      int bad;
      me = q.pop_front();
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rdata[%0d]", k), bus.rdata_o[k*XLEN +: XLEN], me.rdata[k*XLEN +: XLEN]);
      chk("rbusy", XLEN'(bus.rbusy_o), XLEN'(me.rbusy));
      chk("iss_ready", XLEN'(bus.iss_ready_o), XLEN'(me.ready));
      bad = 0;
      for (int r = NREG - 1; r >= 0; r--)
        if (bus.diff_reg_o[r*XLEN +: XLEN] !== me.diff[r*XLEN +: XLEN]) bad = r;
      chk($sformatf("diff_reg[%0d]", bad), bus.diff_reg_o[bad*XLEN +: XLEN], me.diff[bad*XLEN +: XLEN]);
    end
  end

  initial begin
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD*AW-1:0]   ra;
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i = '0;
    bus.flush_i = 1'b0;
    bus.we_i = '0;
    bus.waddr_i = '0;
    bus.wdata_i = '0;
    bus.raddr_i = '0;
    for (int r = 0; r < NREG; r++) begin
      mreg[r] = '0;
      mpend[r] = 0;
    end
    #1 rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 2'b00, '0, '0, '0, 0);
    cyc(0, 0, 0, 2'b00, '0, '0, '0, 1);
    // bypass then stored value of x5
    cyc(0, 0, 0, 2'b01, {5'd0, 5'd5}, {64'h0, 64'h1234}, {5'd0, 5'd5}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd5, 5'd5}, 1);
    // two ports racing on x7 with two reservations outstanding
    cyc(1, 7, 0, 2'b00, '0, '0, {5'd7, 5'd7}, 1);
    cyc(1, 7, 0, 2'b00, '0, '0, {5'd7, 5'd7}, 1);
    cyc(0, 0, 0, 2'b11, {5'd7, 5'd7}, {64'hB, 64'hA}, {5'd0, 5'd7}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd7, 5'd7}, 1);
    // saturate x3, then drain it
    repeat (4) cyc(1, 3, 0, 2'b00, '0, '0, {5'd3, 5'd3}, 1);
    cyc(0, 0, 0, 2'b01, {5'd0, 5'd3}, {64'h0, 64'h33}, {5'd3, 5'd3}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd3, 5'd3}, 1);
    cyc(0, 0, 0, 2'b11, {5'd3, 5'd3}, {64'h35, 64'h34}, {5'd3, 5'd3}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd3, 5'd3}, 1);
    // issue and writeback of x9 in one edge, then writeback at zero
    cyc(1, 9, 0, 2'b00, '0, '0, {5'd9, 5'd9}, 1);
    cyc(1, 9, 0, 2'b10, {5'd9, 5'd0}, {64'h99, 64'h0}, {5'd9, 5'd9}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd9, 5'd9}, 1);
    cyc(0, 0, 0, 2'b01, {5'd0, 5'd9}, {64'h0, 64'h98}, {5'd9, 5'd9}, 1);
    cyc(0, 0, 0, 2'b01, {5'd0, 5'd9}, {64'h0, 64'h97}, {5'd9, 5'd9}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd9, 5'd9}, 1);
    // x0 is never reserved nor written
    cyc(1, 0, 0, 2'b01, {5'd0, 5'd0}, {64'h0, 64'hFF}, {5'd0, 5'd0}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd0, 5'd0}, 1);
    // flush overrides a same-cycle issue
    repeat (2) cyc(1, 4, 0, 2'b00, '0, '0, {5'd4, 5'd4}, 1);
    cyc(1, 4, 1, 2'b00, '0, '0, {5'd4, 5'd4}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd4, 5'd4}, 1);
    // reset mid-sequence
    repeat (3) cyc(1, 6, 0, 2'b01, {5'd0, 5'd5}, {64'h0, 64'h55}, {5'd6, 5'd5}, 1);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd6, 5'd5}, 0);
    cyc(0, 0, 0, 2'b00, '0, '0, {5'd6, 5'd5}, 1);
    cyc(1, 6, 0, 2'b00, '0, '0, {5'd6, 5'd7}, 1);
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < NWR; p++) begin
        wa[p*AW +: AW] = AW'($urandom_range(0, 7));
        wd[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = AW'($urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom_range(0, 49) == 0,
          NWR'($urandom), wa, wd, ra, $urandom_range(0, 199) != 0);
    end
    cyc(0, 0, 0, 2'b00, '0, '0, '0, 1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
